// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the ARM-subset datapath.
// Drives fetch/decode/execute/memory/writeback and keeps NZCV.
module datapath_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          cond,
    input  logic [1:0]          op,
    input  logic [5:0]          funct,
    input  logic [3:0]          alu_flags,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                ir_we,
    output logic                pc_we,
    output logic                rf_we,
    output logic                ram_we,
    output logic                pc_src_branch,
    output logic                alu_src_imm,
    output logic                wb_sel_mem,
    output logic [1:0]          alu_ctrl,
    output logic [3:0]          nzcv,
    output logic                busy,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_HALT
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_e              state_q, state_d;
    logic [3:0]          nzcv_q, nzcv_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire;
    logic                cond_ok;
    logic                fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = nzcv_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = fz;
            4'b0001: cond_ok = ~fz;
            4'b0010: cond_ok = fc;
            4'b0011: cond_ok = ~fc;
            4'b0100: cond_ok = fn;
            4'b0101: cond_ok = ~fn;
            4'b0110: cond_ok = fv;
            4'b0111: cond_ok = ~fv;
            4'b1000: cond_ok = fc & ~fz;
            4'b1001: cond_ok = ~fc | fz;
            4'b1010: cond_ok = (fn == fv);
            4'b1011: cond_ok = (fn != fv);
            4'b1100: cond_ok = ~fz & (fn == fv);
            4'b1101: cond_ok = fz | (fn != fv);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        nzcv_d        = nzcv_q;
        retired_d     = retired_q;
        retire        = 1'b0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        rf_we         = 1'b0;
        ram_we        = 1'b0;
        pc_src_branch = 1'b0;
        alu_src_imm   = 1'b0;
        wb_sel_mem    = 1'b0;
        alu_ctrl      = ALU_ADD;
        busy          = 1'b1;
        halted        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d   = S_FETCH;
                    retired_d = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == 2'b11) begin
                    state_d = S_HALT;
                end else if (!cond_ok) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (op == 2'b00) begin
                    state_d = S_EXEC;
                end else if (op == 2'b01) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_EXEC: begin
                alu_src_imm = funct[5];
                case (funct[4:1])
                    4'b0100: begin
                        alu_ctrl = ALU_ADD;
                        rf_we    = 1'b1;
                        if (funct[0]) nzcv_d = alu_flags;
                    end
                    4'b0010: begin
                        alu_ctrl = ALU_SUB;
                        rf_we    = 1'b1;
                        if (funct[0]) nzcv_d = alu_flags;
                    end
                    4'b0000: begin
                        alu_ctrl = ALU_AND;
                        rf_we    = 1'b1;
                        if (funct[0]) nzcv_d = alu_flags;
                    end
                    4'b1100: begin
                        alu_ctrl = ALU_ORR;
                        rf_we    = 1'b1;
                        if (funct[0]) nzcv_d = alu_flags;
                    end
                    4'b1010: begin
                        alu_ctrl = ALU_SUB;
                        nzcv_d   = alu_flags;
                    end
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEM: begin
                alu_src_imm = 1'b1;
                dmem_req    = 1'b1;
                ram_we      = ~funct[0];
                if (dmem_ready) begin
                    if (funct[0]) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                wb_sel_mem = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                pc_we         = 1'b1;
                pc_src_branch = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (retire) retired_d = retired_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            nzcv_q    <= 4'b0000;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            retired_q <= retired_d;
        end
    end

    assign nzcv    = nzcv_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: directed table, random
// instructions against an instruction-level model, corner sequences.
module tb_datapath_sequencer;

    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    cond = '0;
    logic [1:0]    op = '0;
    logic [5:0]    funct = '0;
    logic [3:0]    alu_flags = '0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, ir_we, pc_we, rf_we, ram_we;
    logic          pc_src_branch, alu_src_imm, wb_sel_mem;
    logic [1:0]    alu_ctrl;
    logic [3:0]    nzcv;
    logic          busy, halted;
    logic [RW-1:0] retired;

    datapath_sequencer #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .cond(cond), .op(op),
        .funct(funct), .alu_flags(alu_flags),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we),
        .pc_we(pc_we), .rf_we(rf_we), .ram_we(ram_we),
        .pc_src_branch(pc_src_branch), .alu_src_imm(alu_src_imm),
        .wb_sel_mem(wb_sel_mem), .alu_ctrl(alu_ctrl), .nzcv(nzcv),
        .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc, irwe, pcwe, pcbr, rf, wbm, ram, dreq, busyl;
        logic [1:0] alu;
        logic       imm;
        logic [3:0] nz;
    } obs_t;

    typedef struct {
        logic [3:0] c;
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] fl;
        int         iw, dw;
        obs_t       e;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] exp_ret;
    logic [3:0]    m_nz;
    vec_t          tbl[15];

    task automatic cmp(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c, input logic [1:0] o,
        input logic [5:0] f, input logic [3:0] fl, input int iw, input int dw,
        input int cyc, input int pcbr, input int rf, input int wbm,
        input int ram, input int dreq, input logic [1:0] alu,
        input logic imm, input logic [3:0] nz);
        vec_t v;
        v.c = c; v.o = o; v.f = f; v.fl = fl; v.iw = iw; v.dw = dw;
        v.e.cyc = cyc; v.e.irwe = 1; v.e.pcwe = 1 + pcbr; v.e.pcbr = pcbr;
        v.e.rf = rf; v.e.wbm = wbm; v.e.ram = ram; v.e.dreq = dreq;
        v.e.busyl = 0; v.e.alu = alu; v.e.imm = imm; v.e.nz = nz;
        return v;
    endfunction

    function automatic bit cpass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1;
            default: return 0;
        endcase
    endfunction

    // Instruction-level model: what one instruction should look like
    // from FETCH entry to the next FETCH entry.
    function automatic obs_t model(input logic [3:0] c, input logic [1:0] o,
        input logic [5:0] f, input logic [3:0] fl, input int iw, input int dw,
        input logic [3:0] nz);
        obs_t e;
        bit   pass;
        e = '{default: 0};
        e.nz = nz;
        e.irwe = 1;
        e.pcwe = 1;
        e.cyc = 2 + iw;
        pass = cpass(c, nz);
        if (pass && o == 2'b00) begin
            e.cyc += 1;
            e.imm = f[5];
            case (f[4:1])
                4'b0100: begin e.alu = 0; e.rf = 1; end
                4'b0010: begin e.alu = 1; e.rf = 1; end
                4'b0000: begin e.alu = 2; e.rf = 1; end
                4'b1100: begin e.alu = 3; e.rf = 1; end
                4'b1010: begin e.alu = 1; e.nz = fl; end
                default: e.alu = 0;
            endcase
            if (e.rf == 1 && f[0]) e.nz = fl;
        end else if (pass && o == 2'b01) begin
            e.cyc += 1 + dw + int'(f[0]);
            e.dreq = 1 + dw;
            e.imm = 1;
            if (f[0]) begin e.rf = 1; e.wbm = 1; end
            else e.ram = 1 + dw;
        end else if (pass && o == 2'b10) begin
            e.cyc += 1;
            e.pcbr = 1;
            e.pcwe = 2;
        end
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
        input logic [5:0] f, input logic [3:0] fl, input int iw, input int dw,
        output obs_t ob);
        int icnt, dcnt;
        bit left, done;
        ob = '{default: 0};
        cond = c; op = o; funct = f; alu_flags = fl;
        icnt = 0; dcnt = 0; left = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            imem_ready = imem_req ? (icnt == iw) : 1'($urandom % 2);
            dmem_ready = dmem_req ? (dcnt == dw) : 1'($urandom % 2);
            start = 1'($urandom % 4 == 0);
            @(negedge clk);
            if (imem_req) icnt++; else left = 1;
            if (dmem_req) dcnt++;
            ob.irwe += int'(ir_we);
            ob.pcwe += int'(pc_we);
            ob.pcbr += int'(pc_we && pc_src_branch);
            ob.rf += int'(rf_we);
            ob.wbm += int'(rf_we && wb_sel_mem);
            ob.ram += int'(ram_we && dmem_req);
            ob.dreq += int'(dmem_req);
            ob.busyl += int'(!busy);
            ob.alu |= alu_ctrl;
            ob.imm |= alu_src_imm;
            ob.cyc++;
            @(posedge clk); #1;
            if (left && imem_req) done = 1;
        end
        start = 1'b0;
        ob.nz = nzcv;
        if (!done) begin
            errors++;
            $display("FAIL instr_timeout got=no_refetch expected=refetch");
        end
    endtask

    task automatic check_obs(input string t, input obs_t g, input obs_t e);
        cmp({t, "_cycles"}, g.cyc, e.cyc);
        cmp({t, "_ir_we"}, g.irwe, e.irwe);
        cmp({t, "_pc_we"}, g.pcwe, e.pcwe);
        cmp({t, "_pc_branch"}, g.pcbr, e.pcbr);
        cmp({t, "_rf_we"}, g.rf, e.rf);
        cmp({t, "_wb_mem"}, g.wbm, e.wbm);
        cmp({t, "_ram_we"}, g.ram, e.ram);
        cmp({t, "_dmem_req"}, g.dreq, e.dreq);
        cmp({t, "_busy_low"}, g.busyl, e.busyl);
        cmp({t, "_alu_ctrl"}, int'(g.alu), int'(e.alu));
        cmp({t, "_alu_imm"}, int'(g.imm), int'(e.imm));
        cmp({t, "_nzcv"}, int'(g.nz), int'(e.nz));
        cmp({t, "_retired"}, int'(retired), int'(exp_ret));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        obs_t g, e;
        int   tot;
        logic [3:0] c;
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] cmds[5];

        tbl[0]  = mk(4'hE, 2'b00, 6'b001001, 4'b0100, 0, 0, 3, 0, 1, 0, 0, 0, 2'd0, 0, 4'b0100);
        tbl[1]  = mk(4'hE, 2'b00, 6'b010100, 4'b0110, 0, 0, 3, 0, 0, 0, 0, 0, 2'd1, 0, 4'b0110);
        tbl[2]  = mk(4'h0, 2'b10, 6'b000000, 4'b0000, 0, 0, 3, 1, 0, 0, 0, 0, 2'd0, 0, 4'b0110);
        tbl[3]  = mk(4'h1, 2'b10, 6'b000000, 4'b0000, 0, 0, 2, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0110);
        tbl[4]  = mk(4'hE, 2'b01, 6'b100001, 4'b0000, 0, 3, 7, 0, 1, 1, 0, 4, 2'd0, 1, 4'b0110);
        tbl[5]  = mk(4'hE, 2'b01, 6'b100000, 4'b0000, 2, 1, 6, 0, 0, 0, 2, 2, 2'd0, 1, 4'b0110);
        tbl[6]  = mk(4'hE, 2'b00, 6'b100100, 4'b1111, 0, 0, 3, 0, 1, 0, 0, 0, 2'd1, 1, 4'b0110);
        tbl[7]  = mk(4'hE, 2'b00, 6'b011111, 4'b1001, 0, 0, 3, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0110);
        tbl[8]  = mk(4'hE, 2'b00, 6'b011001, 4'b1000, 0, 0, 3, 0, 1, 0, 0, 0, 2'd3, 0, 4'b1000);
        tbl[9]  = mk(4'hF, 2'b00, 6'b001001, 4'b0001, 0, 0, 2, 0, 0, 0, 0, 0, 2'd0, 0, 4'b1000);
        tbl[10] = mk(4'hA, 2'b10, 6'b000000, 4'b0000, 0, 0, 2, 0, 0, 0, 0, 0, 2'd0, 0, 4'b1000);
        tbl[11] = mk(4'hB, 2'b10, 6'b000000, 4'b0000, 0, 0, 3, 1, 0, 0, 0, 0, 2'd0, 0, 4'b1000);
        tbl[12] = mk(4'hE, 2'b00, 6'b000001, 4'b0011, 1, 0, 4, 0, 1, 0, 0, 0, 2'd2, 0, 4'b0011);
        tbl[13] = mk(4'h8, 2'b00, 6'b001000, 4'b0000, 0, 0, 3, 0, 1, 0, 0, 0, 2'd0, 0, 4'b0011);
        tbl[14] = mk(4'h9, 2'b00, 6'b001001, 4'b1111, 0, 0, 2, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0011);
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

        repeat (2) @(negedge clk);
        cmp("rst_reqs", int'({imem_req, dmem_req}), 0);
        cmp("rst_wes", int'({ir_we, pc_we, rf_we, ram_we}), 0);
        cmp("rst_sels", int'({pc_src_branch, alu_src_imm, wb_sel_mem}), 0);
        cmp("rst_alu_ctrl", int'(alu_ctrl), 0);
        cmp("rst_status", int'({busy, halted}), 0);
        cmp("rst_nzcv", int'(nzcv), 0);
        cmp("rst_retired", int'(retired), 0);

        @(posedge clk); #1;
        rst = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("idle_ready_ignored", int'({imem_req, dmem_req, ir_we, busy}), 0);
        @(posedge clk); #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        pulse_start();
        exp_ret = '0;

        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].c, tbl[i].o, tbl[i].f, tbl[i].fl,
                      tbl[i].iw, tbl[i].dw, g);
            exp_ret++;
            check_obs($sformatf("tbl%0d", i), g, tbl[i].e);
        end
        m_nz = tbl[14].e.nz;

        for (int i = 0; i < 200; i++) begin
            int iw, dw;
            c = 4'($urandom);
            o = 2'($urandom_range(0, 2));
            f = {1'($urandom), ($urandom % 6 == 5) ? 4'($urandom)
                 : cmds[$urandom % 5], 1'($urandom)};
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            e = model(c, o, f, 4'($urandom), iw, dw, m_nz);
            alu_flags = 4'($urandom);
            e = model(c, o, f, alu_flags, iw, dw, m_nz);
            run_instr(c, o, f, alu_flags, iw, dw, g);
            exp_ret++;
            m_nz = e.nz;
            check_obs($sformatf("rnd%0d", i), g, e);
        end

        cond = 4'hE; op = 2'b01; funct = 6'b100001;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp("midldr_dreq", int'(dmem_req), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        cmp("midrst_dreq", int'(dmem_req), 0);
        cmp("midrst_busy", int'(busy), 0);
        cmp("midrst_retired", int'(retired), 0);
        cmp("midrst_nzcv", int'(nzcv), 0);
        cmp("midrst_wes", int'({rf_we, ram_we, ir_we, pc_we}), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        dmem_ready = 1'b1;
        @(negedge clk);
        cmp("post_rst_strobes",
            int'({imem_req, dmem_req, ir_we, pc_we, rf_we, ram_we}), 0);
        @(posedge clk); #1;
        dmem_ready = 1'b0;

        pulse_start();
        exp_ret = '0;
        run_instr(tbl[0].c, tbl[0].o, tbl[0].f, tbl[0].fl, 0, 0, g);
        exp_ret++;
        check_obs("pre_halt", g, tbl[0].e);
        cond = 4'hE; op = 2'b11; imem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp("halt_halted", int'(halted), 1);
        cmp("halt_busy", int'(busy), 0);
        repeat (3) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        cmp("halt_start_ignored", int'({halted, busy, imem_req}), 4);
        cmp("halt_retired", int'(retired), int'(exp_ret));

        rst = 1'b0;
        #3;
        cmp("halt_rst_exit", int'(halted), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        imem_ready = 1'b0;
        pulse_start();
        exp_ret = '0;
        tot = 0;
        for (int i = 0; i < (1 << RW) + 1; i++) begin
            run_instr(4'hF, 2'b00, 6'b001001, 4'b1111, 0, 0, g);
            tot += g.cyc;
        end
        cmp("wrap_retired", int'(retired), 1);
        cmp("wrap_cycles", tot, 2 * ((1 << RW) + 1));
        cmp("wrap_nzcv", int'(nzcv), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
